hv_reg_access_arb: RTL
======================

HV_REG_ACCESS_ARB -- requirements
Module: hv_reg_access_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter REG_AW, default 7, register address width.
REQ-003 SHALL have parameters REG_DW, default 8, and REG_CRC_W, default 8: register data width and CRC width.
REQ-004 SHALL have parameter TMO_CYC, default 15, maximum WAIT cycles before an error response (1..255).
REQ-005 SHALL have port i_clk  input  1  clock, rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_req_vld  input  NUM_REQ  per-requester request level.
REQ-008 SHALL have port i_req_wr  input  NUM_REQ  per-requester 1 = write, 0 = read.
REQ-009 SHALL have ports i_req_addr/i_req_wdata/i_req_wcrc  input  NUM_REQ*REG_AW / NUM_REQ*REG_DW / NUM_REQ*REG_CRC_W  packed per-requester fields, requester k in slice k.
REQ-010 SHALL have port o_req_gnt  output  NUM_REQ  one-hot grant pulse.
REQ-011 SHALL have port o_rsp_vld  output  NUM_REQ  one-hot response pulse to the owner.
REQ-012 SHALL have port o_rsp_err  output  1  response is a timeout error.
REQ-013 SHALL have ports o_rsp_addr/o_rsp_data/o_rsp_crc  output  REG_AW/REG_DW/REG_CRC_W  response address, data, CRC.
REQ-014 SHALL have ports o_reg_ren/o_reg_wen  output  1  register-file read/write strobes.
REQ-015 SHALL have ports o_reg_addr/o_reg_wdata/o_reg_wcrc  output  REG_AW/REG_DW/REG_CRC_W  register-file access fields.
REQ-016 SHALL have ports i_reg_wack/i_reg_rack  input  1  register-file write/read acknowledges.
REQ-017 SHALL have ports i_reg_rdata/i_reg_rcrc  input  REG_DW/REG_CRC_W  register-file read data and CRC.

Function
REQ-018 SHALL implement FSM IDLE->ISSUE->WAIT->RSP->IDLE, with exactly one outstanding access.
REQ-019 SHALL, in IDLE with any i_req_vld set, select one winner, latch owner, wr, addr, wdata and wcrc, and enter ISSUE at the next edge.
REQ-020 SHALL, in ISSUE, drive o_req_gnt[owner]=1 and o_reg_wen=wr or o_reg_ren=~wr for exactly one cycle, with o_reg_addr/wdata/wcrc holding the latched values.
REQ-021 SHALL, in WAIT, accept only the matching ack (i_reg_wack for a write, i_reg_rack for a read); mismatched acks and acks in any other state are ignored.
REQ-022 SHALL, on a matching ack, capture o_rsp_data/o_rsp_crc (read: i_reg_rdata/i_reg_rcrc; write: latched wdata/wcrc) and o_rsp_addr, then enter RSP with o_rsp_err=0.
REQ-023 SHALL count WAIT cycles with an 8-bit counter cleared on WAIT entry; when the count reaches TMO_CYC with no ack, enter RSP with o_rsp_err=1 and o_rsp_data=0.
REQ-024 SHALL, on an ack and a timeout in the same cycle, treat the ack as taking precedence (o_rsp_err=0).
REQ-025 SHALL, in RSP, pulse o_rsp_vld[owner] for exactly one cycle, then return to IDLE; rsp fields hold until the next RSP.
REQ-026 SHALL give minimum latency of request-to-strobe 1 cycle, and ack-in-first-WAIT-cycle-to-o_rsp_vld 1 cycle.
REQ-027 SHALL treat a requester still high after its response as a new request, and SHALL ignore i_req_vld changes after latching.
REQ-028 SHALL use default arbitration of fixed priority, with the lowest index winning.

Reset
REQ-029 SHALL, on i_rst_n low, go to IDLE and zero every output, the counter, the owner and the RR pointer; an access in flight is dropped without a response.

Configuration
REQ-030 SHALL, with macro HV_REG_ARB_RR_EN defined, arbitrate round-robin: the search starts at the index after the last winner and the pointer updates on entry to ISSUE.
REQ-031 SHALL, without HV_REG_ARB_RR_EN, use the fixed priority of REQ-028 and contain no pointer register.

Structure
REQ-032 SHALL place the FSM state enum typedef and the default TMO_CYC constant in shared package hv_pkg.
REQ-033 SHALL place the winner selection in sub-module hv_arb_pick, a combinational one-hot picker with optional RR pointer input.

Verification
REQ-034 SHALL cover: requester 2 reads addr 0x15, rack 2 cycles after ren with rdata 0xA5 -> o_rsp_vld=4'b0100, data 0xA5, err 0.
REQ-035 SHALL cover: requesters 1 and 3 simultaneously, fixed priority -> req1 served first, then req3; with RR_EN and last winner 1 -> req3 first.
REQ-036 SHALL cover: write with no ack, TMO_CYC=15 -> o_rsp_err=1 exactly 15 cycles after WAIT entry, data 0.
REQ-037 SHALL cover: rack arriving during a write WAIT -> ignored; a wack later completes with err 0.
REQ-038 SHALL cover: i_rst_n asserted in WAIT -> all outputs 0, no o_rsp_vld; a fresh request after release is served normally.

Source files
------------

// File: rtl/hv_pkg.sv
// hv_pkg: shared FSM state encoding and default timeout for the register-access arbiter.
package hv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RSP   = 2'd3
    } hv_state_t;

    localparam int TMO_CYC_DEF = 15;

endpackage

// File: rtl/hv_arb_pick.sv
// hv_arb_pick: combinational one-hot winner picker; scans from index 0, or from ptr+1 when RR_EN.
`default_nettype none

module hv_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter bit RR_EN   = 1'b0
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt
);

    int   start;
    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        start = RR_EN ? ((int'(ptr) + 1) % NUM_REQ) : 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (start + i) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hv_reg_access_arb.sv
// hv_reg_access_arb: N-to-1 register-file access arbiter, one outstanding access with timeout.
// Define HV_REG_ARB_RR_EN for round-robin arbitration (default: fixed priority, lowest index wins).
`default_nettype none

module hv_reg_access_arb
    import hv_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int REG_AW    = 7,
    parameter int REG_DW    = 8,
    parameter int REG_CRC_W = 8,
    parameter int TMO_CYC   = TMO_CYC_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req_vld,
    input  logic [NUM_REQ-1:0]             i_req_wr,
    input  logic [NUM_REQ*REG_AW-1:0]      i_req_addr,
    input  logic [NUM_REQ*REG_DW-1:0]      i_req_wdata,
    input  logic [NUM_REQ*REG_CRC_W-1:0]   i_req_wcrc,
    output logic [NUM_REQ-1:0]             o_req_gnt,
    output logic [NUM_REQ-1:0]             o_rsp_vld,
    output logic                           o_rsp_err,
    output logic [REG_AW-1:0]              o_rsp_addr,
    output logic [REG_DW-1:0]              o_rsp_data,
    output logic [REG_CRC_W-1:0]           o_rsp_crc,
    output logic                           o_reg_ren,
    output logic                           o_reg_wen,
    output logic [REG_AW-1:0]              o_reg_addr,
    output logic [REG_DW-1:0]              o_reg_wdata,
    output logic [REG_CRC_W-1:0]           o_reg_wcrc,
    input  logic                           i_reg_wack,
    input  logic                           i_reg_rack,
    input  logic [REG_DW-1:0]              i_reg_rdata,
    input  logic [REG_CRC_W-1:0]           i_reg_rcrc
);

    localparam int         PTR_W    = $clog2(NUM_REQ);
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    hv_state_t              state;
    hv_state_t              state_nxt;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [NUM_REQ-1:0]     owner;
    logic                   wr_q;
    logic [REG_AW-1:0]      addr_q;
    logic [REG_DW-1:0]      wdata_q;
    logic [REG_CRC_W-1:0]   wcrc_q;
    logic [7:0]             cnt;
    logic                   sel_wr;
    logic [REG_AW-1:0]      sel_addr;
    logic [REG_DW-1:0]      sel_wdata;
    logic [REG_CRC_W-1:0]   sel_wcrc;
    logic                   ack_ok;
    logic                   tmo_hit;
    logic                   take;

`ifdef HV_REG_ARB_RR_EN
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick_idx;

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_oh[k]) pick_idx = PTR_W'(k);
        end
    end

    // Pointer tracks the last winner and moves when the access is latched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  rr_ptr <= '0;
        else if (take) rr_ptr <= pick_idx;
    end

    hv_arb_pick #(.NUM_REQ(NUM_REQ), .RR_EN(1'b1)) u_pick (
        .req (i_req_vld),
        .ptr (rr_ptr),
        .gnt (pick_oh)
    );
`else
    hv_arb_pick #(.NUM_REQ(NUM_REQ), .RR_EN(1'b0)) u_pick (
        .req (i_req_vld),
        .ptr ({PTR_W{1'b0}}),
        .gnt (pick_oh)
    );
`endif

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wcrc  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_oh[k]) begin
                sel_wr    = i_req_wr[k];
                sel_addr  = i_req_addr[k*REG_AW +: REG_AW];
                sel_wdata = i_req_wdata[k*REG_DW +: REG_DW];
                sel_wcrc  = i_req_wcrc[k*REG_CRC_W +: REG_CRC_W];
            end
        end
    end

    assign take    = (state == ST_IDLE) && (|i_req_vld);
    assign ack_ok  = (state == ST_WAIT) && (wr_q ? i_reg_wack : i_reg_rack);
    assign tmo_hit = (state == ST_WAIT) && (cnt == TMO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_req_gnt = '0;
        o_rsp_vld = '0;
        o_reg_wen = 1'b0;
        o_reg_ren = 1'b0;
        case (state)
            ST_IDLE:  if (|i_req_vld) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                o_req_gnt = owner;
                o_reg_wen = wr_q;
                o_reg_ren = ~wr_q;
                state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (ack_ok || tmo_hit) state_nxt = ST_RSP;
            ST_RSP: begin
                o_rsp_vld = owner;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wcrc_q     <= '0;
            cnt        <= '0;
            o_rsp_err  <= 1'b0;
            o_rsp_addr <= '0;
            o_rsp_data <= '0;
            o_rsp_crc  <= '0;
        end else begin
            if (take) begin
                owner   <= pick_oh;
                wr_q    <= sel_wr;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                wcrc_q  <= sel_wcrc;
            end
            if (state == ST_ISSUE)     cnt <= '0;
            else if (state == ST_WAIT) cnt <= cnt + 8'd1;
            // Ack wins over a timeout landing in the same cycle.
            if (ack_ok) begin
                o_rsp_err  <= 1'b0;
                o_rsp_addr <= addr_q;
                o_rsp_data <= wr_q ? wdata_q : i_reg_rdata;
                o_rsp_crc  <= wr_q ? wcrc_q  : i_reg_rcrc;
            end else if (tmo_hit) begin
                o_rsp_err  <= 1'b1;
                o_rsp_addr <= addr_q;
                o_rsp_data <= '0;
                o_rsp_crc  <= '0;
            end
        end
    end

    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_wcrc  = wcrc_q;

endmodule

`default_nettype wire
